// File: rtl/comm_mode_switch_ctrl_if.sv
// comm_mode_switch_ctrl_if: mode request, monitored serial lines and route-select status of the mode switch controller
interface comm_mode_switch_ctrl_if;
    logic mode_req;
    logic bus1_rx;
    logic bus2_rx;
    logic bus3_rx;
    logic sw_mode;
    logic busy;
    logic switch_done;
    logic timeout_flag;
    modport master (
        output mode_req, bus1_rx, bus2_rx, bus3_rx,
        input  sw_mode, busy, switch_done, timeout_flag
    );
    modport slave (
        input  mode_req, bus1_rx, bus2_rx, bus3_rx,
        output sw_mode, busy, switch_done, timeout_flag
    );
endinterface

// File: rtl/comm_mode_switch_ctrl.sv
// comm_mode_switch_ctrl: flips the route-through switch select only after every serial line has been idle for a quiet window
//   clk, reset (asynchronous, active low)
//   sif.slave in : mode_req (level, clk domain), bus1_rx/bus2_rx/bus3_rx (async, idle-high)
//   sif.slave out: sw_mode (route select), busy, switch_done (1-cycle pulse), timeout_flag (sticky)
//   COMM_SWITCH_TIMEOUT_EN: forces the flip after TIMEOUT_CYCLES of waiting and sets timeout_flag
module comm_mode_switch_ctrl #(
    parameter logic INIT_MODE      = 1'b0,
    parameter int   QUIET_CYCLES   = 1042,
    parameter int   HOLDOFF_CYCLES = 16,
    parameter int   TIMEOUT_CYCLES = 65535,
    parameter int   CNT_W          = 16
) (
    input logic                    clk,
    input logic                    reset,
    comm_mode_switch_ctrl_if.slave sif
);
    typedef enum logic [1:0] {IDLE, WAIT_QUIET, HOLDOFF} state_t;
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
    if (QUIET_CYCLES < 1 || HOLDOFF_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
        QUIET_CYCLES > 2**CNT_W || HOLDOFF_CYCLES > 2**CNT_W || TIMEOUT_CYCLES > 2**CNT_W) begin : g_bad_cfg
        $error("CNT_W too narrow for the cycle parameters");
    end
    state_t           state_q, state_d;
    logic [2:0]       sync1_q, sync2_q;
    logic [CNT_W-1:0] quiet_q, quiet_d;
    logic [CNT_W-1:0] holdoff_q, holdoff_d;
    logic             sw_mode_q, sw_mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             lines_idle, flip;
`ifdef COMM_SWITCH_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             tflag_q, tflag_d;
`endif
    // Lines are only trusted after the second synchronizer stage.
    assign lines_idle = &sync2_q;
    always_comb begin
        state_d   = state_q;
        sw_mode_d = sw_mode_q;
        quiet_d   = quiet_q;
        holdoff_d = holdoff_q;
        done_d    = 1'b0;
        flip      = 1'b0;
`ifdef COMM_SWITCH_TIMEOUT_EN
        wait_d    = wait_q;
        tflag_d   = tflag_q;
`endif
        case (state_q)
            IDLE: begin
                if (sif.mode_req != sw_mode_q) begin
                    state_d = WAIT_QUIET;
                    quiet_d = '0;
`ifdef COMM_SWITCH_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end
            end
            WAIT_QUIET: begin
                // Cancel beats any flip; a quiet flip beats a forced one.
                if (sif.mode_req == sw_mode_q) begin
                    state_d = IDLE;
                end else if (lines_idle && quiet_q == QUIET_LAST) begin
                    flip = 1'b1;
`ifdef COMM_SWITCH_TIMEOUT_EN
                    tflag_d = 1'b0;
                end else if (wait_q == WAIT_LAST) begin
                    flip    = 1'b1;
                    tflag_d = 1'b1;
`endif
                end else begin
                    quiet_d = lines_idle ? quiet_q + CNT_W'(1) : '0;
`ifdef COMM_SWITCH_TIMEOUT_EN
                    wait_d  = wait_q + CNT_W'(1);
`endif
                end
            end
            HOLDOFF: begin
                if (holdoff_q == HOLD_LAST) state_d = IDLE;
                else holdoff_d = holdoff_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        if (flip) begin
            state_d   = HOLDOFF;
            sw_mode_d = ~sw_mode_q;
            done_d    = 1'b1;
            holdoff_d = '0;
        end
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sync1_q   <= '1;
            sync2_q   <= '1;
            quiet_q   <= '0;
            holdoff_q <= '0;
            sw_mode_q <= INIT_MODE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef COMM_SWITCH_TIMEOUT_EN
            wait_q    <= '0;
            tflag_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= {sif.bus3_rx, sif.bus2_rx, sif.bus1_rx};
            sync2_q   <= sync1_q;
            quiet_q   <= quiet_d;
            holdoff_q <= holdoff_d;
            sw_mode_q <= sw_mode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef COMM_SWITCH_TIMEOUT_EN
            wait_q    <= wait_d;
            tflag_q   <= tflag_d;
`endif
        end
    end
    assign sif.sw_mode     = sw_mode_q;
    assign sif.busy        = busy_q;
    assign sif.switch_done = done_q;
`ifdef COMM_SWITCH_TIMEOUT_EN
    assign sif.timeout_flag = tflag_q;
`else
    assign sif.timeout_flag = 1'b0;
`endif
endmodule
